// File: rtl/sync_cnt_pkg.sv
// Shared types and defaults for the loadable down-counter timer.
package sync_cnt_pkg;

  localparam int CNT_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } cnt_state_t;

endpackage

// File: rtl/sync_down_counter_core.sv
// Count register for the down-counter timer: load has priority over decrement.
module down_cnt_core
  import sync_cnt_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_ld,
  input  logic [WIDTH-1:0] i_ld_val,
  input  logic             i_dec,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_is_one,
  output logic             o_is_zero
);

  logic [WIDTH-1:0] r_cnt;

  // Decrement wraps naturally from zero to all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_ld) begin
      r_cnt <= i_ld_val;
    end else if (i_dec) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign o_cnt     = r_cnt;
  assign o_is_one  = (r_cnt == WIDTH'(1));
  assign o_is_zero = (r_cnt == '0);

endmodule

// File: rtl/sync_down_counter.sv
// Programmable interval timer: FSM, reload register and tc/done flags.
// Optional periodic mode is compiled in with SYNC_DOWN_CNT_AUTORELOAD_EN.
//   state | meaning
//   IDLE  | after reset, waiting for first load
//   RUN   | counting down on enabled clocks
//   HALT  | one-shot expired, count parked at zero
module sync_down_counter
  import sync_cnt_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] b,
  output logic             tc,
  output logic             done,
  output logic             busy
);

  cnt_state_t       r_state;
  logic             r_tc;
  logic             r_done;
  logic             w_is_one;
  logic             w_is_zero;
  logic             w_term;
  logic             w_reload_now;
  logic [WIDTH-1:0] w_reload_val;
  logic             w_clear;
  logic             w_core_ld;
  logic             w_core_dec;
  logic [WIDTH-1:0] w_core_val;

  // A load on the terminal edge pre-empts the terminal event entirely.
  assign w_term = (r_state == RUN) & en & w_is_one & ~load;

`ifdef SYNC_DOWN_CNT_AUTORELOAD_EN
  logic [WIDTH-1:0] r_reload;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reload <= '0;
    end else if (load) begin
      r_reload <= load_val;
    end
  end

  assign w_reload_now = w_term & auto_reload;
  assign w_reload_val = r_reload;
`else
  logic w_unused_auto_reload;

  assign w_unused_auto_reload = auto_reload;
  assign w_reload_now         = 1'b0;
  assign w_reload_val         = '0;
`endif

  // Keeps the parked count pinned at zero while halted.
  assign w_clear    = (r_state == HALT) & ~w_is_zero & ~load;
  assign w_core_ld  = load | w_reload_now | w_clear;
  assign w_core_val = load ? load_val : (w_reload_now ? w_reload_val : '0);
  assign w_core_dec = (r_state == RUN) & en;

  down_cnt_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .i_ld     (w_core_ld),
    .i_ld_val (w_core_val),
    .i_dec    (w_core_dec),
    .o_cnt    (b),
    .o_is_one (w_is_one),
    .o_is_zero(w_is_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_tc    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_tc <= w_term;
      if (load) begin
        r_state <= RUN;
        r_done  <= 1'b0;
      end else if (w_term && !w_reload_now) begin
        r_state <= HALT;
        r_done  <= 1'b1;
      end
    end
  end

  assign tc   = r_tc;
  assign done = r_done;
  assign busy = (r_state == RUN);

endmodule

// File: tb/tb_sync_down_counter.sv
// Self-checking bench for sync_down_counter: integer reference model plus directed literal checks.
module tb_sync_down_counter;
  localparam int W   = 4;
  localparam int MOD = 1 << W;
`ifdef SYNC_DOWN_CNT_AUTORELOAD_EN
  localparam bit HAS_RELOAD = 1'b1;
`else
  localparam bit HAS_RELOAD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         auto_reload = 1'b0;
  logic [W-1:0] b;
  logic         tc, done, busy;

  int n_checks = 0;
  int n_errors = 0;
  bit started  = 1'b0;

  sync_down_counter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .auto_reload(auto_reload), .b(b), .tc(tc), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: remaining count as an integer, plus mode flags.
  int m_count  = 0;
  int m_period = 0;
  bit m_run    = 1'b0;
  bit m_done   = 1'b0;
  bit m_tc     = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_count = 0; m_period = 0; m_run = 0; m_done = 0; m_tc = 0;
    end else begin
      m_tc = 0;
      if (load) begin
        m_count  = int'(load_val);
        m_period = int'(load_val);
        m_run    = 1; m_done = 0;
      end else if (m_run && en) begin
        if (m_count == 1) begin
          m_tc = 1;
          if (HAS_RELOAD && auto_reload) m_count = m_period;
          else begin m_count = 0; m_run = 0; m_done = 1; end
        end else begin
          m_count = (m_count + MOD - 1) % MOD;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("model_b", int'(b), m_count);
      chk("model_tc", int'(tc), int'(m_tc));
      chk("model_done", int'(done), int'(m_done));
      chk("model_busy", int'(busy), int'(m_run));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input int v, input bit ar, input bit e);
    load = 1; load_val = W'(v); auto_reload = ar; en = e;
    step(1);
    load = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1;
    step(2);
    chk("reset_b", int'(b), 0);
    chk("reset_busy", int'(busy), 0);
    rst = 0;
    started = 1;

    // IDLE ignores en
    en = 1; step(3);
    chk("idle_hold_b", int'(b), 0);
    chk("idle_busy", int'(busy), 0);

    // async reset mid-count with b=9
    do_load(9, 0, 0);
    chk("t1_loaded", int'(b), 9);
    #2 rst = 1;
    #1;
    chk("t1_async_b", int'(b), 0);
    chk("t1_async_flags", int'({tc, done, busy}), 0);
    step(1);
    rst = 0;

    // one-shot load 5
    do_load(5, 0, 1);
    chk("t2_first", int'(b), 5);
    for (int k = 4; k >= 1; k--) begin
      step(1);
      chk("t2_count", int'(b), k);
      chk("t2_no_tc", int'(tc), 0);
    end
    step(1);
    chk("t2_tc_b", int'(b), 0);
    chk("t2_tc", int'(tc), 1);
    step(1);
    chk("t2_tc_once", int'(tc), 0);
    chk("t2_done", int'(done), 1);
    chk("t2_busy", int'(busy), 0);
    step(3);
    chk("t2_halt_b", int'(b), 0);

    // en toggling after load 4
    do_load(4, 0, 0);
    chk("t5_b4", int'(b), 4);
    chk("t5_done_cleared", int'(done), 0);
    en = 1; step(1); chk("t5_b3", int'(b), 3);
    en = 0; step(1); chk("t5_b3h", int'(b), 3);
    en = 1; step(1); chk("t5_b2", int'(b), 2);
    en = 0; step(1); chk("t5_b2h", int'(b), 2);
    chk("t5_no_tc", int'(tc), 0);
    en = 1; step(2);
    chk("t5_end_tc", int'(tc), 1);

    // load 0 gives 2**W counts
    do_load(0, 0, 1);
    chk("t4_zero", int'(b), 0);
    chk("t4_busy", int'(busy), 1);
    for (int i = 1; i < MOD; i++) begin
      step(1);
      chk("t4_count", int'(b), MOD - i);
      chk("t4_no_tc", int'(tc), 0);
    end
    step(1);
    chk("t4_tc", int'(tc), 1);
    chk("t4_b", int'(b), 0);

    // load on the terminal edge wins
    do_load(2, 0, 1);
    step(1);
    chk("t6_pre", int'(b), 1);
    load = 1; load_val = 7;
    step(1);
    load = 0;
    chk("t6_b", int'(b), 7);
    chk("t6_tc", int'(tc), 0);
    chk("t6_done", int'(done), 0);
    chk("t6_busy", int'(busy), 1);

    // auto_reload request, period 3
    do_load(3, 1, 1);
    chk("t3_first", int'(b), 3);
    step(2);
    chk("t3_b1", int'(b), 1);
    step(1);
    if (HAS_RELOAD) begin
      chk("t3_reload_b", int'(b), 3);
      chk("t3_reload_tc", int'(tc), 1);
      chk("t3_reload_done", int'(done), 0);
      step(3);
      chk("t3_second_tc", int'(tc), 1);
      chk("t3_busy", int'(busy), 1);
    end else begin
      chk("t3_oneshot_b", int'(b), 0);
      chk("t3_oneshot_tc", int'(tc), 1);
      chk("t3_oneshot_done", int'(done), 1);
      step(3);
      chk("t3_oneshot_halt", int'(busy), 0);
    end

    // periodic with load 0, model-checked
    do_load(0, 1, 1);
    step(40);
    en = 0; step(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
